// File: rtl/kex_stream_reader.sv
// Read-side sequencer for the 1x1 expansion-kernel tile RAM.
// Streams LEN words from BASE (mod N_ELEM) through a 2-entry skid FIFO.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               begin a burst (sampled in IDLE only)
//   i_base_addr, i_len    burst base address and length (len clamps to N_ELEM)
//   o_busy, o_done        burst in progress / 1-cycle completion pulse
//   o_ram_addr            RAM read address; o_ram_write tied 0
//   o_ram_own             RAM port-mux select (= o_busy)
//   i_ram_res             RAM read data, valid 1 cycle after the address
//   o_out_data/valid/last stream to the PE array; i_out_ready backpressure
module kex_stream_reader #(
    parameter int DATA_W = 16,
    parameter int N_ELEM = 32,
    parameter int AW     = $clog2(N_ELEM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [AW-1:0]     i_base_addr,
    input  logic [AW:0]       i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [AW-1:0]     o_ram_addr,
    output logic              o_ram_write,
    output logic              o_ram_own,
    input  logic [DATA_W-1:0] i_ram_res,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    localparam logic [AW:0]   LP_N         = (AW+1)'(N_ELEM);
    localparam logic [AW-1:0] LP_LAST_ADDR = AW'(N_ELEM - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [AW-1:0]     r_addr;
    logic [AW:0]       r_cnt_iss;
    logic [AW:0]       r_len;
    logic              r_pend;
    logic              r_pend_last;
    logic              r_done;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic [1:0]        r_fifo_cnt;

    logic [AW:0]       w_len_c;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_iss_last;
    logic [AW-1:0]     w_addr_nxt;
    logic              w_wr_idx;
    logic              w_accept;
    logic              w_done_nxt;

    assign w_len_c    = (i_len > LP_N) ? LP_N : i_len;
    assign w_pop      = o_out_valid & i_out_ready;
    assign w_push     = r_pend;
    // Slots committed next cycle: buffered + in flight - leaving now.
    assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue    = (r_state == S_ISSUE) && (w_occ < 3'd2);
    assign w_iss_last = (r_cnt_iss == r_len - 1'b1);
    assign w_addr_nxt = (r_addr == LP_LAST_ADDR) ? '0 : r_addr + 1'b1;
    // Push slot after a same-cycle pop shifts the head down.
    assign w_wr_idx   = r_fifo_cnt[1] | (r_fifo_cnt[0] & ~w_pop);

    assign o_ram_addr  = r_addr;
    assign o_ram_write = 1'b0;
    assign o_ram_own   = o_busy;
    assign o_done      = r_done;
    assign o_out_data  = r_fifo_data[0];
    assign o_out_valid = (r_fifo_cnt != 2'd0);
    assign o_out_last  = o_out_valid & r_fifo_last[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        o_busy      = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    if (w_len_c != '0) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (w_issue && w_iss_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_fifo_last[0]) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_cnt_iss   <= '0;
            r_len       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_done      <= 1'b0;
            r_fifo_cnt  <= 2'd0;
            r_fifo_last <= 2'b00;
        end else begin
            r_done      <= w_done_nxt;
            r_pend      <= w_issue;
            r_pend_last <= w_issue & w_iss_last;
            if (w_accept) begin
                r_addr    <= i_base_addr;
                r_len     <= w_len_c;
                r_cnt_iss <= '0;
            end else if (w_issue) begin
                r_addr    <= w_addr_nxt;
                r_cnt_iss <= r_cnt_iss + 1'b1;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_fifo_last[0] <= r_fifo_last[1];
            end
            if (w_push) begin
                r_fifo_last[w_wr_idx] <= r_pend_last;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pop) begin
            r_fifo_data[0] <= r_fifo_data[1];
        end
        if (w_push) begin
            r_fifo_data[w_wr_idx] <= i_ram_res;
        end
    end

endmodule

// File: tb/tb_kex_stream_reader.sv
// Self-checking bench for kex_stream_reader.
// Random RAM contents and ready patterns against a queue reference model.
module tb_kex_stream_reader;

    localparam int DW = 16;
    localparam int N  = 32;
    localparam int AW = $clog2(N);

    logic          clk;
    logic          i_rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_len;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_write;
    logic          o_ram_own;
    logic [DW-1:0] ram_res;
    logic [DW-1:0] o_out_data;
    logic          o_out_valid;
    logic          i_out_ready;
    logic          o_out_last;

    logic [DW-1:0] mem [N];

    int n_tests;
    int n_fail;

    kex_stream_reader #(
        .DATA_W (DW),
        .N_ELEM (N)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_addr  (o_ram_addr),
        .o_ram_write (o_ram_write),
        .o_ram_own   (o_ram_own),
        .i_ram_res   (ram_res),
        .o_out_data  (o_out_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_last  (o_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM: data appears one cycle after the address.
    always @(posedge clk) ram_res <= mem[o_ram_addr];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rmode 0: always ready; 1: toggle plus 5-cycle stall; 2: random.
    task automatic burst(input int base, input int len, input int rmode,
                         input int inject);
        int exp_q[$];
        int eff;
        int n;
        bit fin;
        bit first_seen;
        bit stalled;
        logic [DW-1:0] held;
        logic [DW-1:0] exp_d;
        eff = (len > N) ? N : len;
        for (int i = 0; i < eff; i++) exp_q.push_back(int'(mem[(base + i) % N]));
        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = AW'(base);
        i_len       = (AW+1)'(len);
        @(negedge clk);
        i_start = 1'b0;
        if (eff == 0) begin
            check("len0_done", o_done, 1);
            check("len0_busy", o_busy, 0);
            check("len0_valid", o_out_valid, 0);
            @(negedge clk);
            check("len0_done_drop", o_done, 0);
            check("len0_valid2", o_out_valid, 0);
            return;
        end
        check("busy", o_busy, 1);
        check("own", o_ram_own, 1);
        check("write", o_ram_write, 0);
        n = 0;
        fin = 0;
        first_seen = 0;
        stalled = 0;
        held = '0;
        while (!fin && n < 2000) begin
            if (n == inject) begin
                i_start     = 1'b1;
                i_base_addr = AW'(base + 3);
                i_len       = (AW+1)'(5);
            end else begin
                i_start = 1'b0;
            end
            if (o_out_valid && !first_seen) begin
                first_seen = 1;
                check("latency", 64'(n), 2);
            end
            if (stalled) begin
                check("hold_valid", o_out_valid, 1);
                check("hold_data", o_out_data, held);
                stalled = 0;
            end
            case (rmode)
                0: i_out_ready = 1'b1;
                1: i_out_ready = (n >= 8 && n < 13) ? 1'b0 : 1'(n % 2);
                default: i_out_ready = 1'($urandom_range(0, 1));
            endcase
            if (o_out_valid) begin
                if (i_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 1, 0);
                        fin = 1;
                    end else begin
                        exp_d = DW'(exp_q.pop_front());
                        check("data", o_out_data, exp_d);
                        check("last", o_out_last, exp_q.size() == 0);
                        if (exp_q.size() == 0) begin
                            check("done_early", o_done, 0);
                            @(negedge clk);
                            i_start = 1'b0;
                            check("done", o_done, 1);
                            check("busy_end", o_busy, 0);
                            check("valid_end", o_out_valid, 0);
                            @(negedge clk);
                            check("done_pulse", o_done, 0);
                            fin = 1;
                        end
                    end
                end else begin
                    stalled = 1;
                    held = o_out_data;
                end
            end
            if (!fin) begin
                @(negedge clk);
                n++;
            end
        end
        i_start = 1'b0;
        if (!fin) check("timeout", 0, 1);
        i_out_ready = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        i_rst = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_len = '0;
        i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_valid", o_out_valid, 0);
        check("rst_last", o_out_last, 0);
        check("rst_addr", o_ram_addr, 0);
        check("rst_write", o_ram_write, 0);
        check("rst_own", o_ram_own, 0);

        burst(0, 8, 0, -1);
        burst(N - 2, 4, 0, -1);
        burst(5, 16, 1, -1);
        burst(7, 0, 0, -1);
        burst(3, 10, 0, 4);
        burst(20, 3, 2, -1);

        // Reset with words outstanding while the sink stalls.
        @(negedge clk);
        i_out_ready = 1'b0;
        i_start = 1'b1;
        i_base_addr = AW'(4);
        i_len = (AW+1)'(8);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", o_out_valid, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_valid", o_out_valid, 0);
        check("mid_rst_done", o_done, 0);
        @(negedge clk);
        check("post_rst_done", o_done, 0);
        check("post_rst_valid", o_out_valid, 0);
        i_out_ready = 1'b1;
        burst(12, 2, 0, -1);

        burst(9, N + 5, 2, -1);
        for (int k = 0; k < 12; k++) begin
            burst(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N + 3)),
                  int'($urandom_range(0, 2)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
